// File: rtl/buyruk_onbellegi_if.sv
// Fetch-side and main-memory-side signals of the instruction cache.
interface buyruk_onbellegi_if;
  logic [31:0] buyruk_adres_i;
  logic        durdur_i;
  logic        gecersiz_kil_i;
  logic [31:0] buyruk_o;
  logic        buyruk_hazir_o;
  logic        bellek_istek_o;
  logic [31:0] bellek_adres_o;
  logic [31:0] bellek_veri_i;
  logic        bellek_gecerli_i;

  modport slave (
    input  buyruk_adres_i, durdur_i, gecersiz_kil_i, bellek_veri_i, bellek_gecerli_i,
    output buyruk_o, buyruk_hazir_o, bellek_istek_o, bellek_adres_o
  );

  modport master (
    output buyruk_adres_i, durdur_i, gecersiz_kil_i, bellek_veri_i, bellek_gecerli_i,
    input  buyruk_o, buyruk_hazir_o, bellek_istek_o, bellek_adres_o
  );
endinterface

// File: rtl/buyruk_onbellegi.sv
// Direct-mapped instruction cache; hit pulses the cycle after address capture, miss refills a whole line first.
// Stall only blocks address capture; the hit pulse and refill never wait on it.
module buyruk_onbellegi #(
  parameter int SATIR_SAYISI  = 64,
  parameter int KELIME_SAYISI = 4
) (
  input logic               clk_i,
  input logic               rst_i,
  buyruk_onbellegi_if.slave bus
);
  localparam int OW = $clog2(KELIME_SAYISI);
  localparam int IW = $clog2(SATIR_SAYISI);
  localparam int LB = OW + 2;
  localparam int TB = LB + IW;
  localparam int TW = 32 - TB;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic {ARA, DOLDUR} durum_t;

  durum_t                  durum_r;
  logic [31:2]             adres_r;
  logic                    istek_r;
  logic                    bekleyen_r;
  logic [31:LB]            doldur_adres_r;
  logic [OW-1:0]           sayac_r;
  logic [SATIR_SAYISI-1:0] gecerli_r;
  logic [TW-1:0]           etiket_r [SATIR_SAYISI];
  logic [31:0]             veri_r   [SATIR_SAYISI][KELIME_SAYISI];

  logic [OW-1:0] ofs;
  logic [IW-1:0] idx;
  logic [TW-1:0] etk;
  logic [IW-1:0] d_idx;
  logic          son_vurus;
  logic          isabet;
  logic          gecersiz_et;
  logic          cevap;
  logic          iska;

  assign ofs         = adres_r[LB-1:2];
  assign idx         = adres_r[TB-1:LB];
  assign etk         = adres_r[31:TB];
  assign d_idx       = doldur_adres_r[TB-1:LB];
  assign son_vurus   = bus.bellek_gecerli_i && (sayac_r == OW'(KELIME_SAYISI - 1));
  assign isabet      = gecerli_r[idx] && (etiket_r[idx] == etk);
  // A pending invalidate left over from a refill forces a miss before any compare.
  assign gecersiz_et = bus.gecersiz_kil_i || bekleyen_r;
  assign cevap       = (durum_r == ARA) && istek_r && isabet && !gecersiz_et;
  assign iska        = (durum_r == ARA) && istek_r && !cevap;

  assign bus.buyruk_hazir_o = cevap;
  assign bus.buyruk_o       = cevap ? veri_r[idx][ofs] : NOP;
  assign bus.bellek_istek_o = (durum_r == DOLDUR);
  assign bus.bellek_adres_o = {doldur_adres_r, {LB{1'b0}}};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      durum_r        <= ARA;
      adres_r        <= '0;
      istek_r        <= 1'b0;
      bekleyen_r     <= 1'b0;
      doldur_adres_r <= '0;
      sayac_r        <= '0;
      gecerli_r      <= '0;
    end else begin
      if (!bus.durdur_i) begin
        adres_r <= bus.buyruk_adres_i[31:2];
        istek_r <= 1'b1;
      end else if (cevap) begin
        istek_r <= 1'b0;
      end

      case (durum_r)
        ARA: begin
          if (gecersiz_et) begin
            gecerli_r  <= '0;
            bekleyen_r <= 1'b0;
          end
          if (iska) begin
            doldur_adres_r <= adres_r[31:LB];
            sayac_r        <= '0;
            durum_r        <= DOLDUR;
          end
        end
        DOLDUR: begin
          if (bus.gecersiz_kil_i) bekleyen_r <= 1'b1;
          if (bus.bellek_gecerli_i) begin
            sayac_r <= sayac_r + 1'b1;
            if (son_vurus) begin
              gecerli_r[d_idx] <= 1'b1;
              durum_r          <= ARA;
            end
          end
        end
        default: durum_r <= ARA;
      endcase
    end
  end

  // Line storage carries no reset; the valid bits alone decide what is usable.
  always_ff @(posedge clk_i) begin
    if (!rst_i && (durum_r == DOLDUR) && bus.bellek_gecerli_i) begin
      veri_r[d_idx][sayac_r] <= bus.bellek_veri_i;
      if (son_vurus) etiket_r[d_idx] <= doldur_adres_r[31:TB];
    end
  end
endmodule

// File: tb/tb_buyruk_onbellegi.sv
// Directed bench for the instruction cache: inputs change 1ns after posedge, outputs sampled at negedge.
module tb_buyruk_onbellegi;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  buyruk_onbellegi_if bus();

  buyruk_onbellegi #(.SATIR_SAYISI(64), .KELIME_SAYISI(4)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic        o_hz, o_ist;
  logic [31:0] o_bo, o_ad;
  logic        r_hz  [8];
  logic        r_ist [8];
  logic [31:0] r_bo  [8];
  logic [31:0] r_ad  [8];

  // One clock cycle: apply inputs for the cycle, then capture outputs mid-cycle.
  task automatic cyc(input logic [31:0] a, input logic st, input logic inv,
                     input logic bv, input logic [31:0] bd, input logic r);
    @(posedge clk);
    #1;
    bus.buyruk_adres_i   = a;
    bus.durdur_i         = st;
    bus.gecersiz_kil_i   = inv;
    bus.bellek_gecerli_i = bv;
    bus.bellek_veri_i    = bd;
    rst                  = r;
    @(negedge clk);
    o_hz  = bus.buyruk_hazir_o;
    o_ist = bus.bellek_istek_o;
    o_bo  = bus.buyruk_o;
    o_ad  = bus.bellek_adres_o;
  endtask

  // Accept a, stall, feed four back-to-back beats d0.., then two idle cycles.
  task automatic miss_seq(input logic [31:0] a, input logic [31:0] d0, input int inv_at);
    for (int c = 0; c < 8; c++) begin
      cyc(a, c != 0, c == inv_at, (c >= 2 && c <= 5),
          (c >= 2 && c <= 5) ? d0 + 32'(c - 2) : 32'h0, 1'b0);
      r_hz[c]  = o_hz;
      r_ist[c] = o_ist;
      r_bo[c]  = o_bo;
      r_ad[c]  = o_ad;
    end
  endtask

  task automatic test_reset();
    cyc(32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    n_cmp++; if (o_hz !== 1'b0) begin n_bad++; $display("FAIL rst_hazir: got %b want 0", o_hz); end
    n_cmp++; if (o_bo !== 32'h13) begin n_bad++; $display("FAIL rst_buyruk: got %h want 00000013", o_bo); end
    n_cmp++; if (o_ist !== 1'b0) begin n_bad++; $display("FAIL rst_istek: got %b want 0", o_ist); end
    n_cmp++; if (o_ad !== 32'h0) begin n_bad++; $display("FAIL rst_adres: got %h want 0", o_ad); end
    cyc(32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    cyc(32'h0, 1'b1, 1'b0, 1'b1, 32'hdead, 1'b0);
    n_cmp++; if (o_hz !== 1'b0) begin n_bad++; $display("FAIL idle_hazir: got %b want 0", o_hz); end
    n_cmp++; if (o_ist !== 1'b0) begin n_bad++; $display("FAIL stray_beat_istek: got %b want 0", o_ist); end
  endtask

  task automatic test_cold_miss();
    miss_seq(32'h108, 32'hA0, -1);
    for (int c = 0; c < 8; c++) begin
      n_cmp++;
      if (r_ist[c] !== (c >= 2 && c <= 5)) begin
        n_bad++; $display("FAIL cold_istek[%0d]: got %b want %b", c, r_ist[c], (c >= 2 && c <= 5));
      end
      n_cmp++;
      if (r_hz[c] !== (c == 6)) begin
        n_bad++; $display("FAIL cold_hazir[%0d]: got %b want %b", c, r_hz[c], (c == 6));
      end
      if (c >= 2 && c <= 5) begin
        n_cmp++;
        if (r_ad[c] !== 32'h100) begin n_bad++; $display("FAIL cold_adres[%0d]: got %h want 00000100", c, r_ad[c]); end
      end
    end
    n_cmp++; if (r_bo[6] !== 32'hA2) begin n_bad++; $display("FAIL cold_buyruk: got %h want 000000a2", r_bo[6]); end
  endtask

  task automatic test_streaming();
    for (int i = 0; i < 6; i++) begin
      cyc((i < 4) ? 32'h100 + 32'(4 * i) : 32'h10C, i >= 4, 1'b0, 1'b0, 32'h0, 1'b0);
      n_cmp++;
      if (o_hz !== (i >= 1 && i <= 4)) begin
        n_bad++; $display("FAIL stream_hazir[%0d]: got %b want %b", i, o_hz, (i >= 1 && i <= 4));
      end
      n_cmp++;
      if (o_ist !== 1'b0) begin n_bad++; $display("FAIL stream_istek[%0d]: got %b want 0", i, o_ist); end
      if (i >= 1 && i <= 4) begin
        n_cmp++;
        if (o_bo !== 32'hA0 + 32'(i - 1)) begin
          n_bad++; $display("FAIL stream_buyruk[%0d]: got %h want %h", i, o_bo, 32'hA0 + 32'(i - 1));
        end
      end
    end
  endtask

  task automatic test_stall();
    logic        exp_hz [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [31:0] exp_bo [6] = '{32'h13, 32'hA1, 32'h13, 32'h13, 32'h13, 32'hA3};
    logic        st     [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 6; i++) begin
      cyc((i == 0) ? 32'h104 : 32'h10C, st[i], 1'b0, 1'b0, 32'h0, 1'b0);
      n_cmp++;
      if (o_hz !== exp_hz[i]) begin n_bad++; $display("FAIL stall_hazir[%0d]: got %b want %b", i, o_hz, exp_hz[i]); end
      n_cmp++;
      if (o_bo !== exp_bo[i]) begin n_bad++; $display("FAIL stall_buyruk[%0d]: got %h want %h", i, o_bo, exp_bo[i]); end
    end
    cyc(32'h10C, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    n_cmp++; if (o_hz !== 1'b0) begin n_bad++; $display("FAIL stall_single: got %b want 0", o_hz); end
  endtask

  task automatic test_conflict();
    logic [31:0] adr [2] = '{32'h500, 32'h100};
    logic [31:0] dat [2] = '{32'hB0, 32'hA0};
    for (int k = 0; k < 2; k++) begin
      miss_seq(adr[k], dat[k], -1);
      n_cmp++; if (r_hz[1] !== 1'b0) begin n_bad++; $display("FAIL conflict_hit[%0d]: got %b want 0", k, r_hz[1]); end
      n_cmp++; if (r_ist[2] !== 1'b1) begin n_bad++; $display("FAIL conflict_istek[%0d]: got %b want 1", k, r_ist[2]); end
      n_cmp++; if (r_ad[2] !== adr[k]) begin n_bad++; $display("FAIL conflict_adres[%0d]: got %h want %h", k, r_ad[2], adr[k]); end
      n_cmp++; if (r_ist[6] !== 1'b0) begin n_bad++; $display("FAIL conflict_istek_end[%0d]: got %b want 0", k, r_ist[6]); end
      n_cmp++; if (r_hz[6] !== 1'b1) begin n_bad++; $display("FAIL conflict_hazir[%0d]: got %b want 1", k, r_hz[6]); end
      n_cmp++; if (r_bo[6] !== dat[k]) begin n_bad++; $display("FAIL conflict_buyruk[%0d]: got %h want %h", k, r_bo[6], dat[k]); end
    end
  endtask

  task automatic test_invalidate();
    miss_seq(32'h200, 32'hC0, 3);
    for (int c = 2; c < 8; c++) begin
      n_cmp++;
      if (r_ist[c] !== (c != 6)) begin n_bad++; $display("FAIL inv_istek[%0d]: got %b want %b", c, r_ist[c], (c != 6)); end
    end
    n_cmp++; if (r_hz[6] !== 1'b0) begin n_bad++; $display("FAIL inv_stale_hit: got %b want 0", r_hz[6]); end
    n_cmp++; if (r_ad[7] !== 32'h200) begin n_bad++; $display("FAIL inv_refill_adres: got %h want 00000200", r_ad[7]); end
    for (int w = 0; w < 4; w++) begin
      cyc(32'h200, 1'b1, 1'b0, 1'b1, 32'hD0 + 32'(w), 1'b0);
      n_cmp++; if (o_ist !== 1'b1) begin n_bad++; $display("FAIL inv_beat_istek[%0d]: got %b want 1", w, o_ist); end
    end
    cyc(32'h200, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    n_cmp++; if (o_hz !== 1'b1) begin n_bad++; $display("FAIL inv_hazir: got %b want 1", o_hz); end
    n_cmp++; if (o_bo !== 32'hD0) begin n_bad++; $display("FAIL inv_buyruk: got %h want 000000d0", o_bo); end
    cyc(32'h200, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    n_cmp++; if (o_hz !== 1'b0) begin n_bad++; $display("FAIL inv_single: got %b want 0", o_hz); end
  endtask

  task automatic test_reset_mid_refill();
    cyc(32'h300, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    cyc(32'h300, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    cyc(32'h300, 1'b1, 1'b0, 1'b1, 32'hE0, 1'b0);
    cyc(32'h300, 1'b1, 1'b0, 1'b1, 32'hE1, 1'b1);
    n_cmp++; if (o_ist !== 1'b1) begin n_bad++; $display("FAIL rstmid_istek_before: got %b want 1", o_ist); end
    cyc(32'h300, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    n_cmp++; if (o_ist !== 1'b0) begin n_bad++; $display("FAIL rstmid_istek: got %b want 0", o_ist); end
    n_cmp++; if (o_bo !== 32'h13) begin n_bad++; $display("FAIL rstmid_buyruk: got %h want 00000013", o_bo); end
    miss_seq(32'h300, 32'hF0, -1);
    for (int c = 0; c < 8; c++) begin
      n_cmp++;
      if (r_ist[c] !== (c >= 2 && c <= 5)) begin
        n_bad++; $display("FAIL rstmid_miss_istek[%0d]: got %b want %b", c, r_ist[c], (c >= 2 && c <= 5));
      end
      n_cmp++;
      if (r_hz[c] !== (c == 6)) begin
        n_bad++; $display("FAIL rstmid_miss_hazir[%0d]: got %b want %b", c, r_hz[c], (c == 6));
      end
    end
    n_cmp++; if (r_ad[2] !== 32'h300) begin n_bad++; $display("FAIL rstmid_adres: got %h want 00000300", r_ad[2]); end
    n_cmp++; if (r_bo[6] !== 32'hF0) begin n_bad++; $display("FAIL rstmid_refill_buyruk: got %h want 000000f0", r_bo[6]); end
  endtask

  initial begin
    bus.buyruk_adres_i   = 32'h0;
    bus.durdur_i         = 1'b1;
    bus.gecersiz_kil_i   = 1'b0;
    bus.bellek_gecerli_i = 1'b0;
    bus.bellek_veri_i    = 32'h0;
    test_reset();
    test_cold_miss();
    test_streaming();
    test_stall();
    test_conflict();
    test_invalidate();
    test_reset_mid_refill();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
